regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_if.sv | 43 ++++
 rtl/regfile_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus: two valid/ready write requesters, the
// register-file write port, and the pending/busy status outputs.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   req0_valid;
  logic [ADDR_W-1:0]      req0_rd;
  logic [DATA_W-1:0]      req0_data;
  logic                   req0_ready;

  logic                   req1_valid;
  logic [ADDR_W-1:0]      req1_rd;
  logic [DATA_W-1:0]      req1_data;
  logic                   req1_ready;

  logic [ADDR_W-1:0]      rf_rd;
  logic [DATA_W-1:0]      rf_writedata;
  logic                   rf_regwrite;

  logic [(2**ADDR_W)-1:0] pend_mask;
  logic                   busy;

  // Requester side: issues writes and observes the write port and status.
  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  rf_rd, rf_writedata, rf_regwrite,
    input  pend_mask, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output rf_rd, rf_writedata, rf_regwrite,
    output pend_mask, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter. Each requester has a one-entry
// buffer; a round-robin pointer picks between two full buffers, and the
// winner is registered into the write-port output stage. Writes to x0 are
// accepted and dropped at the buffer input.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int NREG = 2 ** ADDR_W;

  // One-hot decode of a register index, gated by its valid flag.
  function automatic logic [NREG-1:0] rd_onehot(input logic vld, input logic [ADDR_W-1:0] rd);
    logic [NREG-1:0] res;
    if (vld) begin
      res = NREG'(1) << rd;
    end else begin
      res = {NREG{1'b0}};
    end
    return res;
  endfunction

  logic              buf0_valid_r, buf1_valid_r;
  logic [ADDR_W-1:0] buf0_rd_r, buf1_rd_r;
  logic [DATA_W-1:0] buf0_data_r, buf1_data_r;
  logic              rr_r;
  logic              out_valid_r;
  logic [ADDR_W-1:0] out_rd_r;
  logic [DATA_W-1:0] out_data_r;

  logic gnt0_s, gnt1_s;
  logic ready0_s, ready1_s;
  logic keep0_s, keep1_s;

  // Grant: a lone full buffer wins outright; two full buffers defer to rr (0 -> req0).
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (buf0_valid_r && buf1_valid_r) begin
      gnt0_s = ~rr_r;
      gnt1_s = rr_r;
    end else begin
      gnt0_s = buf0_valid_r;
      gnt1_s = buf1_valid_r;
    end
  end

  // Ready comes only from registered state so requesters see no valid->ready path.
  assign ready0_s = ~buf0_valid_r | gnt0_s;
  assign ready1_s = ~buf1_valid_r | gnt1_s;

  // A handshake only occupies the buffer when it targets a writable register.
  assign keep0_s = bus.req0_valid & ready0_s & (bus.req0_rd != {ADDR_W{1'b0}});
  assign keep1_s = bus.req1_valid & ready1_s & (bus.req1_rd != {ADDR_W{1'b0}});

  // Requester 0 buffer: refill on an accepted write, otherwise drain when granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_valid_r <= 1'b0;
      buf0_rd_r    <= {ADDR_W{1'b0}};
      buf0_data_r  <= {DATA_W{1'b0}};
    end else if (keep0_s) begin
      buf0_valid_r <= 1'b1;
      buf0_rd_r    <= bus.req0_rd;
      buf0_data_r  <= bus.req0_data;
    end else if (gnt0_s) begin
      buf0_valid_r <= 1'b0;
    end
  end

  // Requester 1 buffer: refill on an accepted write, otherwise drain when granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf1_valid_r <= 1'b0;
      buf1_rd_r    <= {ADDR_W{1'b0}};
      buf1_data_r  <= {DATA_W{1'b0}};
    end else if (keep1_s) begin
      buf1_valid_r <= 1'b1;
      buf1_rd_r    <= bus.req1_rd;
      buf1_data_r  <= bus.req1_data;
    end else if (gnt1_s) begin
      buf1_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer moves to the requester that just lost or was idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= 1'b0;
    end else if (gnt0_s) begin
      rr_r <= 1'b1;
    end else if (gnt1_s) begin
      rr_r <= 1'b0;
    end
  end

  // Output stage: register the granted entry; idle cycles drop the enable and keep index/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_rd_r    <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
    end else if (gnt0_s) begin
      out_valid_r <= 1'b1;
      out_rd_r    <= buf0_rd_r;
      out_data_r  <= buf0_data_r;
    end else if (gnt1_s) begin
      out_valid_r <= 1'b1;
      out_rd_r    <= buf1_rd_r;
      out_data_r  <= buf1_data_r;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.req0_ready   = ready0_s;
  assign bus.req1_ready   = ready1_s;
  assign bus.rf_regwrite  = out_valid_r;
  assign bus.rf_rd        = out_rd_r;
  assign bus.rf_writedata = out_data_r;
  assign bus.pend_mask    = rd_onehot(buf0_valid_r, buf0_rd_r)
                          | rd_onehot(buf1_valid_r, buf1_rd_r)
                          | rd_onehot(out_valid_r, out_rd_r);
  assign bus.busy         = buf0_valid_r | buf1_valid_r | out_valid_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a scoreboard queue holds the
// expected (rd, data) write sequence and a monitor pops it on every
// rf_regwrite pulse; scenario tasks check handshake, status and timing inline.
module tb_regfile_wr_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EW     = ADDR_W + DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int pulse_cnt = 0;
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rf_mirror [0:(2**ADDR_W)-1];

  // Monitor: each write pulse must match the head of the scoreboard.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.rf_regwrite === 1'b1) begin
        pulse_cnt++;
        rf_mirror[bus.rf_rd] = bus.rf_writedata;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write", bus.rf_rd, bus.rf_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rf_rd, bus.rf_writedata} !== e) begin
            n_bad++;
            $display("FAIL write_seq: got rd=%0d data=0x%08h, expected rd=%0d data=0x%08h",
                     bus.rf_rd, bus.rf_writedata, e[EW-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask, bus.busy, bus.req0_ready, bus.req1_ready}
        !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got we=%0b rd=%0d wd=0x%08h pend=0x%08h busy=%0b r0=%0b r1=%0b, expected 0/0/0/0/0/1/1",
               bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask, bus.busy, bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if (dut.rr_r !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rr: got %0b, expected 0", dut.rr_r);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready: got %0b, expected 1", bus.req0_ready);
    end
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'h33;
    exp_q.push_back({5'd3, 32'h33});
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_cmp++;
    if ({bus.rf_regwrite, bus.busy, bus.pend_mask} !== {1'b0, 1'b1, 32'h8}) begin
      n_bad++;
      $display("FAIL single_buffered: got we=%0b busy=%0b pend=0x%08h, expected 0/1/0x00000008", bus.rf_regwrite, bus.busy, bus.pend_mask);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask} !== {1'b1, 5'd3, 32'h33, 32'h8}) begin
      n_bad++;
      $display("FAIL single_out: got we=%0b rd=%0d wd=0x%08h pend=0x%08h, expected 1/3/0x33/0x8",
               bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_regwrite, bus.busy, bus.pend_mask, bus.rf_rd, bus.rf_writedata} !== {1'b0, 1'b0, 32'h0, 5'd3, 32'h33}) begin
      n_bad++;
      $display("FAIL single_idle: got we=%0b busy=%0b pend=0x%08h rd=%0d wd=0x%08h, expected 0/0/0/3(held)/0x33(held)",
               bus.rf_regwrite, bus.busy, bus.pend_mask, bus.rf_rd, bus.rf_writedata);
    end
  endtask

  task automatic test_req1_single();
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd7; bus.req1_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    @(negedge clk);
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut.rr_r !== 1'b0) begin
      n_bad++;
      $display("FAIL req1_rr: got %0b, expected 0", dut.rr_r);
    end
  endtask

  task automatic test_x0_drop();
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 32'hFF;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({bus.rf_regwrite, bus.pend_mask, bus.busy, bus.req1_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL x0_drop: got we=%0b pend=0x%08h busy=%0b r1=%0b, expected 0/0/0/1",
                 bus.rf_regwrite, bus.pend_mask, bus.busy, bus.req1_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = 32'h22;
    exp_q.push_back({5'd1, 32'h11});
    exp_q.push_back({5'd2, 32'h22});
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.pend_mask} !== {1'b1, 1'b0, 32'h6}) begin
      n_bad++;
      $display("FAIL contend_ready: got r0=%0b r1=%0b pend=0x%08h, expected 1/0/0x6", bus.req0_ready, bus.req1_ready, bus.pend_mask);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_regwrite, bus.rf_rd, bus.req1_ready} !== {1'b1, 5'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL contend_first: got we=%0b rd=%0d r1=%0b, expected 1/1/1", bus.rf_regwrite, bus.rf_rd, bus.req1_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.rf_regwrite, bus.rf_rd, dut.rr_r} !== {1'b1, 5'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL contend_second: got we=%0b rd=%0d rr=%0b, expected 1/2/0", bus.rf_regwrite, bus.rf_rd, dut.rr_r);
    end
    @(negedge clk);
  endtask

  task automatic test_same_rd();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd6; bus.req0_data = 32'h66;
    exp_q.push_back({5'd6, 32'h66});
    @(negedge clk);
    bus.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut.rr_r !== 1'b1) begin
      n_bad++;
      $display("FAIL same_rd_rr: got %0b, expected 1", dut.rr_r);
    end
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 32'h4;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd5; bus.req1_data = 32'h7;
    exp_q.push_back({5'd5, 32'h7});
    exp_q.push_back({5'd5, 32'h4});
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rf_mirror[5] !== 32'h4) begin
      n_bad++;
      $display("FAIL same_rd_final: got x5=0x%08h, expected 0x00000004", rf_mirror[5]);
    end
  endtask

  task automatic test_streaming();
    int i0 = 0;
    int i1 = 0;
    int cyc = 0;
    int start = pulse_cnt;
    logic hs0, hs1;
    // rr points at requester 1 here, so requester 1 leads the alternation.
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({5'(9 + k), 32'hB000_0000 + 32'(k)});
      exp_q.push_back({5'(1 + k), 32'hA000_0000 + 32'(k)});
    end
    while ((i0 < 8 || i1 < 8) && cyc < 64) begin
      @(negedge clk);
      bus.req0_valid = (i0 < 8); bus.req0_rd = 5'(1 + i0); bus.req0_data = 32'hA000_0000 + 32'(i0);
      bus.req1_valid = (i1 < 8); bus.req1_rd = 5'(9 + i1); bus.req1_data = 32'hB000_0000 + 32'(i1);
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      if (hs0) i0++;
      if (hs1) i1++;
      cyc++;
    end
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_cmp++;
    if (i0 != 8 || i1 != 8) begin
      n_bad++;
      $display("FAIL stream_accept: got %0d/%0d handshakes in %0d cycles, expected 8/8", i0, i1, cyc);
    end
    for (int w = 0; w < 20 && bus.busy !== 1'b0; w++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (pulse_cnt - start != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got %0d pulses, %0d left expected, expected 16 pulses, 0 left", pulse_cnt - start, exp_q.size());
    end
  endtask

  task automatic test_midop_reset();
    int snap;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_rd = 5'd10; bus.req0_data = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_rd = 5'd11; bus.req1_data = 32'hB;
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.pend_mask} !== {1'b1, 32'h0000_0C00}) begin
      n_bad++;
      $display("FAIL midrst_full: got busy=%0b pend=0x%08h, expected 1/0x00000c00", bus.busy, bus.pend_mask);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask, bus.busy, bus.req0_ready, bus.req1_ready}
        !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_state: got we=%0b rd=%0d wd=0x%08h pend=0x%08h busy=%0b r0=%0b r1=%0b, expected 0/0/0/0/0/1/1",
               bus.rf_regwrite, bus.rf_rd, bus.rf_writedata, bus.pend_mask, bus.busy, bus.req0_ready, bus.req1_ready);
    end
    snap = pulse_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pulse_cnt != snap || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_nowrite: got %0d pulses busy=%0b after reset, expected 0 pulses busy=0", pulse_cnt - snap, bus.busy);
    end
    test_single_write();
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_rd = 5'd0; bus.req0_data = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_rd = 5'd0; bus.req1_data = 32'd0;
    for (int r = 0; r < 32; r++) rf_mirror[r] = 32'd0;
    test_reset();
    test_single_write();
    test_req1_single();
    test_x0_drop();
    test_contention();
    test_same_rd();
    test_streaming();
    test_midop_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got %0d writes still expected, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
